// File: rtl/multi_source_select_debounce.sv
// Multi-channel jumper/selector debounce with prescaled sampling and a
// retriggerable "selection changed" pulse plus mask of changed channels.
module multi_source_select_debounce #(
   parameter int unsigned NCH          = 2,
   parameter int unsigned TICK_BITS    = 16,
   parameter int unsigned STABLE_TICKS = 2,
   parameter int unsigned PULSE_TICKS  = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] select,
   output logic [NCH-1:0] selectionresult,
   output logic           selectionchanged,
   output logic [NCH-1:0] changedmask,
   output logic           tick
);

   localparam int unsigned CW  = $clog2(STABLE_TICKS + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW:0] STABLE_MAX = CW1'(STABLE_TICKS);
   localparam logic [3:0]  PULSE_LOAD = 4'(PULSE_TICKS);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_PULSE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [TICK_BITS-1:0] prescale_q, prescale_d;
   logic [NCH-1:0]       sync1_q, sync1_d;
   logic [NCH-1:0]       sync2_q, sync2_d;
   logic [NCH-1:0]       result_q, result_d;
   logic                 changed_q, changed_d;
   logic [NCH-1:0]       mask_q, mask_d;
   logic [3:0]           pulse_q, pulse_d;
   logic [CW-1:0]        stable_q [NCH];
   logic [CW-1:0]        stable_d [NCH];
   logic [NCH-1:0]       accept;
   logic [CW:0]          inc;

   assign tick             = &prescale_q;
   assign selectionresult  = result_q;
   assign selectionchanged = changed_q;
   assign changedmask      = mask_q;

   always_comb begin
      prescale_d = prescale_q + 1'b1;
      sync1_d    = select;
      sync2_d    = sync1_q;
      state_d    = state_q;
      result_d   = result_q;
      changed_d  = changed_q;
      mask_d     = mask_q;
      pulse_d    = pulse_q;
      stable_d   = stable_q;
      accept     = '0;
      inc        = '0;
      if (tick) begin
         if (state_q == ST_INIT) begin
            result_d  = sync2_q;
            mask_d    = '1;
            changed_d = 1'b1;
            pulse_d   = PULSE_LOAD;
            state_d   = ST_PULSE;
         end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (sync2_q[i] == result_q[i]) begin
                  stable_d[i] = '0;
               end else begin
                  inc = {1'b0, stable_q[i]} + 1'b1;
                  if (inc == STABLE_MAX) begin
                     result_d[i] = sync2_q[i];
                     stable_d[i] = '0;
                     accept[i]   = 1'b1;
                  end else begin
                     stable_d[i] = inc[CW-1:0];
                  end
               end
            end
            // Any accept (re)starts the pulse; the mask only accumulates
            // while a pulse is already running.
            if (|accept) begin
               changed_d = 1'b1;
               pulse_d   = PULSE_LOAD;
               mask_d    = (state_q == ST_PULSE) ? (mask_q | accept) : accept;
               state_d   = ST_PULSE;
            end else if (state_q != ST_IDLE) begin
               pulse_d = pulse_q - 1'b1;
               if (pulse_q <= 4'd1) begin
                  pulse_d   = '0;
                  changed_d = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         prescale_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         result_q   <= '0;
         changed_q  <= 1'b0;
         mask_q     <= '0;
         pulse_q    <= '0;
         stable_q   <= '{default: '0};
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         result_q   <= result_d;
         changed_q  <= changed_d;
         mask_q     <= mask_d;
         pulse_q    <= pulse_d;
         stable_q   <= stable_d;
      end
   end

endmodule

// File: tb/tb_multi_source_select_debounce.sv
// Bench for multi_source_select_debounce: directed test-plan steps followed by
// random selector activity, checked against a tick-level behavioural model.
module tb_multi_source_select_debounce;

   localparam int NCH    = 4;
   localparam int TB     = 4;
   localparam int STABLE = 3;
   localparam int PULSE  = 2;
   localparam int PERIOD = 1 << TB;

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] sel_r;
   logic [NCH-1:0] selectionresult;
   logic           selectionchanged;
   logic [NCH-1:0] changedmask;
   logic           tick;

   multi_source_select_debounce #(
      .NCH(NCH), .TICK_BITS(TB), .STABLE_TICKS(STABLE), .PULSE_TICKS(PULSE)
   ) dut (
      .clk(clk), .reset(reset), .select(sel_r),
      .selectionresult(selectionresult), .selectionchanged(selectionchanged),
      .changedmask(changedmask), .tick(tick)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int ph     = 0;

   // Model: results, disagreement run lengths, and the tick at which the pulse ends.
   logic [NCH-1:0] m_res, m_mask;
   logic           m_chg;
   bit             m_init;
   int             m_run [NCH];
   int             m_tick, m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_res = '0; m_mask = '0; m_chg = 1'b0; m_init = 1'b1;
      m_tick = 0; m_pend = 0;
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
   endtask

   task automatic model_tick();
      logic [NCH-1:0] acc;
      bit was_active;
      acc = '0;
      m_tick++;
      was_active = (m_tick - 1) < m_pend;
      if (m_init) begin
         m_res  = sel_r;
         m_mask = '1;
         m_pend = m_tick + PULSE;
         m_init = 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sel_r[i] == m_res[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == STABLE) begin
                  m_res[i] = sel_r[i];
                  m_run[i] = 0;
                  acc[i]   = 1'b1;
               end
            end
         end
         if (acc != 0) begin
            m_mask = was_active ? (m_mask | acc) : acc;
            m_pend = m_tick + PULSE;
         end
      end
      m_chg = m_tick < m_pend;
   endtask

   task automatic clk1();
      chk("tick", {31'd0, tick}, {31'd0, ph == PERIOD - 1});
      if (ph == 7) begin
         chk("hold_result",  {28'd0, selectionresult}, {28'd0, m_res});
         chk("hold_changed", {31'd0, selectionchanged}, {31'd0, m_chg});
         chk("hold_mask",    {28'd0, changedmask}, {28'd0, m_mask});
      end
      @(posedge clk); #1;
      if (ph == PERIOD - 1) begin
         model_tick();
         chk("result",  {28'd0, selectionresult}, {28'd0, m_res});
         chk("changed", {31'd0, selectionchanged}, {31'd0, m_chg});
         chk("mask",    {28'd0, changedmask}, {28'd0, m_mask});
      end
      ph = (ph + 1) % PERIOD;
   endtask

   task automatic run_ticks(input int n);
      repeat (n * PERIOD) clk1();
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] r, input logic c, input logic [3:0] m);
      chk({tag, "_result"},  {28'd0, selectionresult}, {28'd0, r});
      chk({tag, "_changed"}, {31'd0, selectionchanged}, {31'd0, c});
      chk({tag, "_mask"},    {28'd0, changedmask}, {28'd0, m});
   endtask

   initial begin
      reset = 1'b0;
      sel_r = 4'b1010;
      model_reset();
      #23;
      chk_outs("reset", 4'b0000, 1'b0, 4'b0000);
      chk("reset_tick", {31'd0, tick}, 32'd0);
      @(negedge clk) reset = 1'b1;
      ph = 0;

      // Power-up: INIT copies the selection, pulse falls at the 3rd tick.
      run_ticks(1);
      chk_outs("init", 4'b1010, 1'b1, 4'b1111);
      run_ticks(1);
      chk("init_pulse2", {31'd0, selectionchanged}, 32'd1);
      run_ticks(1);
      chk("init_fall", {31'd0, selectionchanged}, 32'd0);
      run_ticks(2);

      // Glitch reject, twice, proving the run counter cleared in between.
      sel_r = 4'b1011; run_ticks(2);
      sel_r = 4'b1010; run_ticks(2);
      chk_outs("glitch1", 4'b1010, 1'b0, 4'b1111);
      sel_r = 4'b1011; run_ticks(2);
      sel_r = 4'b1010; run_ticks(1);
      chk_outs("glitch2", 4'b1010, 1'b0, 4'b1111);

      // Accept on channel 2.
      sel_r = 4'b1110; run_ticks(2);
      chk("acc_pending", {28'd0, selectionresult}, 32'hA);
      run_ticks(1);
      chk_outs("accept", 4'b1110, 1'b1, 4'b0100);
      run_ticks(1);
      chk("accept_hold", {31'd0, selectionchanged}, 32'd1);
      run_ticks(1);
      chk("accept_fall", {31'd0, selectionchanged}, 32'd0);

      // Retrigger: ch0 at tick N, ch3 at N+1.
      run_ticks(1);
      sel_r = 4'b1111; run_ticks(1);
      sel_r = 4'b0111; run_ticks(2);
      chk_outs("retrig_n", 4'b1111, 1'b1, 4'b0001);
      run_ticks(1);
      chk_outs("retrig_n1", 4'b0111, 1'b1, 4'b1001);
      run_ticks(1);
      chk("retrig_n2", {31'd0, selectionchanged}, 32'd1);
      run_ticks(1);
      chk("retrig_n3", {31'd0, selectionchanged}, 32'd0);

      // Simultaneous accept on ch1 and ch2.
      sel_r = 4'b0001; run_ticks(3);
      chk_outs("simul", 4'b0001, 1'b1, 4'b0110);

      // Reset mid-pulse, then INIT repeats.
      repeat (8) clk1();
      reset = 1'b0;
      #1;
      chk_outs("midrst", 4'b0000, 1'b0, 4'b0000);
      chk("midrst_tick", {31'd0, tick}, 32'd0);
      model_reset();
      ph = 0;
      sel_r = 4'b0101;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      run_ticks(1);
      chk_outs("reinit", 4'b0101, 1'b1, 4'b1111);
      run_ticks(3);

      // Random selector activity: flips and glitches of varying length.
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(3) == 0) sel_r[i] = ~sel_r[i];
         run_ticks(1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
